// File: rtl/led_share_if.sv
// LED-share bus: requester levels and patterns in, owner/LED drive back out.
interface led_share_if #(
    parameter int NUM_REQ = 3,
    parameter int LED_W   = 8
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*LED_W-1:0] req_data;
    logic [NUM_REQ-1:0]       grant;
    logic [LED_W-1:0]         led_out;
    logic                     busy;

    modport master (
        output req, req_data,
        input  grant, led_out, busy
    );

    modport slave (
        input  req, req_data,
        output grant, led_out, busy
    );
endinterface

// File: rtl/led_share_arbiter.sv
// Round-robin LED bank sharing with a minimum hold time per owner and
// optional immediate takeover by requester 0 (HPS PIO).
module led_share_arbiter #(
    parameter int               NUM_REQ      = 3,
    parameter int               LED_W        = 8,
    parameter int               HOLD_CYCLES  = 50000000,
    parameter int               CNT_W        = 26,
    parameter logic [LED_W-1:0] IDLE_PATTERN = '0,
    parameter bit               PREEMPT0     = 1'b1
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    led_share_if.slave  bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, OWN} state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    state_t             state;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   rr_last;
    logic [CNT_W-1:0]   hold_cnt;
    logic [NUM_REQ-1:0] grant_q;
    logic [LED_W-1:0]   led_q;
    logic               busy_q;

    logic [NUM_REQ-1:0] others;
    pick_t              pick_all;
    pick_t              pick_oth;
    logic               nxt_valid;
    logic [IDX_W-1:0]   nxt_owner;
    logic               change;

    // First set bit after 'last', wrapping; scanning forward keeps fairness.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] mask,
                                      input logic [IDX_W-1:0]   last);
        pick_t p;
        int    i;
        p = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            i = (int'(last) + off) % NUM_REQ;
            if (!p.found && mask[i]) begin
                p.found = 1'b1;
                p.idx   = IDX_W'(i);
            end
        end
        return p;
    endfunction

    assign others   = bus.req & ~grant_q;
    assign pick_all = rr_pick(bus.req, rr_last);
    assign pick_oth = rr_pick(others, rr_last);

    always_comb begin
        nxt_valid = 1'b0;
        nxt_owner = owner;
        change    = 1'b0;
        case (state)
            IDLE: begin
                if (pick_all.found) begin
                    nxt_valid = 1'b1;
                    nxt_owner = pick_all.idx;
                    change    = 1'b1;
                end
            end
            default: begin
                if (!bus.req[owner]) begin
                    // Release never waits for hold; requester 0 still wins a tie.
                    change = 1'b1;
                    if (PREEMPT0 && bus.req[0]) begin
                        nxt_valid = 1'b1;
                        nxt_owner = '0;
                    end else if (pick_oth.found) begin
                        nxt_valid = 1'b1;
                        nxt_owner = pick_oth.idx;
                    end
                end else if (PREEMPT0 && owner != '0 && bus.req[0]) begin
                    nxt_valid = 1'b1;
                    nxt_owner = '0;
                    change    = 1'b1;
                end else if (hold_cnt == '0 && |others) begin
                    nxt_valid = 1'b1;
                    nxt_owner = pick_oth.idx;
                    change    = 1'b1;
                end else begin
                    nxt_valid = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state    <= IDLE;
            owner    <= '0;
            rr_last  <= IDX_W'(NUM_REQ - 1);
            hold_cnt <= '0;
            grant_q  <= '0;
            led_q    <= IDLE_PATTERN;
            busy_q   <= 1'b0;
        end else begin
            led_q <= nxt_valid ? bus.req_data[int'(nxt_owner)*LED_W +: LED_W] : IDLE_PATTERN;
            if (change && nxt_valid) begin
                state    <= OWN;
                owner    <= nxt_owner;
                rr_last  <= nxt_owner;
                hold_cnt <= CNT_W'(HOLD_CYCLES - 1);
                grant_q  <= NUM_REQ'(1) << nxt_owner;
                busy_q   <= 1'b1;
            end else if (change) begin
                // rr_last kept so the next search resumes after the last owner.
                state    <= IDLE;
                hold_cnt <= '0;
                grant_q  <= '0;
                busy_q   <= 1'b0;
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 1'b1;
            end
        end
    end

    assign bus.grant   = grant_q;
    assign bus.led_out = led_q;
    assign bus.busy    = busy_q;
endmodule
